regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Write-back side of the single-cycle/multi-cycle core. Merges ALU results and load-unit results into the register file's single write port (WE/wR/wD).
- ALU results are never stalled. Load results are buffered in a small FIFO and drain on cycles when the ALU is idle.
- Keeps a per-register pending-load scoreboard so decode can stall on RAW/WAW hazards against loads that have not yet been written back.

Parameters:
- LDQ_DEPTH, 4, load-result FIFO entries (power of 2, >=2)
- PTR_W, 2, log2(LDQ_DEPTH)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle; no backpressure
- alu_rd  in  5  ALU destination register
- alu_wd  in  32  ALU result data
- ld_issue  in  1  load issued this cycle; marks ld_issue_rd pending
- ld_issue_rd  in  5  destination of the issued load
- ld_valid  in  1  load data valid
- ld_rd  in  5  load destination register
- ld_wd  in  32  load data
- ld_ready  out  1  FIFO can accept; handshake completes when ld_valid&&ld_ready
- chk_rs1  in  5  decode source 1
- chk_rs2  in  5  decode source 2
- chk_rd  in  5  decode destination
- stall  out  1  combinational hazard flag
- WE  out  1  register-file write enable, registered
- wR  out  5  register-file write address, registered
- wD  out  32  register-file write data, registered

Behaviour:
- Reset (rst=1 at a clk edge):
  - WE=0, wR=0, wD=0.
  - FIFO empty, pointers 0, count 0.
  - pending[31:0]=0.
  - ld_ready=0 while rst is high; it equals !full from the first cycle after reset.
- Reset mid-operation discards buffered loads and all pending bits. No write issues on the reset cycle or on the first edge after it.
- Source select each cycle, combinational, evaluated in priority order:
  1. alu_valid.
  2. FIFO head, if count>0.
  3. Bypass of an incoming handshake (ld_valid&&ld_ready) when the FIFO is empty.
- The selected source is registered into WE/wR/wD at the next edge, so latency is 1 cycle for every source.
- No source selected: WE=0 at the next edge; wR/wD hold.
- rd==0 from any source:
  - WE stays 0; the result is consumed and dropped.
  - A FIFO head with rd==0 is still popped.
- FIFO push rule: a handshake load is pushed unless it is taken by bypass.
  - Push and pop in the same cycle leaves count unchanged.
  - Full (count==LDQ_DEPTH) drives ld_ready=0; a simultaneous pop does not raise ld_ready in that same cycle.
  - Pointers wrap modulo LDQ_DEPTH.
- ALU starvation of loads is permitted. The FIFO stalls upstream via ld_ready.
- Scoreboard:
  - ld_issue with ld_issue_rd!=0 sets pending[ld_issue_rd] at the next edge.
  - A registered write sourced from the load path (FIFO or bypass) clears pending[wR] at the edge where WE is registered.
  - Set and clear of the same index in the same cycle: set wins.
  - ALU writes never clear pending bits.
  - pending[0] is constant 0.
- stall = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd].
  - Consequence: at most one outstanding load per rd, and no ALU WAW against a pending load.
  - stall does not account for the 1-cycle output register. The register file's same-cycle write/read gap is covered by decode forwarding, outside this block.

Decomposition:
- Shared package:
  - REG_ADDR_W=5, XLEN=32.
  - Source-select encoding: SRC_NONE, SRC_ALU, SRC_FIFO, SRC_BYP.
- One sub-module, wb_ldq_fifo: a synchronous FIFO with push/pop/full/empty/count, parameterised by LDQ_DEPTH and a width of REG_ADDR_W+XLEN.
- Arbiter, scoreboard and output register stay in the top module.

Test Plan:
- Reset:
  - Stimulus: drive rst=1 for 2 cycles with alu_valid=1, rd=3.
  - Required: WE=0, wR=0, wD=0, ld_ready=0. After release, ld_ready=1 and stall=0 for all chk values.
- ALU path:
  - Stimulus: alu_valid rd=5 wd=0x1234_5678 at cycle N.
  - Required: WE=1, wR=5, wD=0x12345678 at N+1; WE=0 at N+2. Same with rd=0: WE never asserts.
- Load bypass and scoreboard:
  - Stimulus: ld_issue rd=7 at N; chk_rs1=7 at N+1.
  - Required: stall=1 at N+1.
  - Stimulus: ld_valid rd=7 wd=0xDEAD_BEEF at N+3 with ALU idle.
  - Required: WE=1, wR=7 at N+4; pending[7] cleared, so stall=0 at N+4.
- Conflict buffering:
  - Stimulus: alu_valid every cycle N..N+5 (rd=1) while 5 loads (rd=10..14) are offered from N.
  - Required: 4 loads accepted; ld_ready=0 after the 4th. When ALU stops at N+6, writes are rd 10,11,12,13 in order on consecutive cycles, then rd 14.
- Set/clear collision:
  - Stimulus: load rd=9 written back in the same cycle as a new ld_issue rd=9.
  - Required: pending[9] remains 1; chk_rs2=9 gives stall=1.
- Reset mid-operation:
  - Stimulus: 3 loads queued and pending[4]=1, then rst for 1 cycle.
  - Required: no further WE; FIFO empty; stall=0 for chk_rs1=4.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared types for the register-file write-back arbiter.
//   REG_ADDR_W / XLEN : register address and data widths
//   wb_src_e          : which source drives the write port this cycle
//   wb_req_t          : {rd, wd} pair carried by every write-back source
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_BYP  = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wd;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Load-unit result handshake into the write-back arbiter.
//   ld_valid : load data valid          (master -> slave)
//   ld_rd    : load destination register (master -> slave)
//   ld_wd    : load data                (master -> slave)
//   ld_ready : arbiter can accept       (slave -> master)
// A transfer completes on a clock edge where ld_valid && ld_ready.
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic                  ld_valid;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_wd;
    logic                  ld_ready;

    modport master (output ld_valid, ld_rd, ld_wd, input  ld_ready);
    modport slave  (input  ld_valid, ld_rd, ld_wd, output ld_ready);

endinterface

// File: rtl/regfile_wb_arbiter_wb_ldq_fifo.sv
// -----------------------------------------------------------------------------
// wb_ldq_fifo
// Synchronous load-result FIFO (first-word-fall-through on dout).
//   clk, rst     : clock, synchronous active-high reset
//   push, din    : write an entry (ignored when full)
//   pop, dout    : dout is the head entry; pop removes it (ignored when empty)
//   full, empty  : occupancy flags
//   count        : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap for free.
// -----------------------------------------------------------------------------
module wb_ldq_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of every other register, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it was written, and leaving it out keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Merges ALU and load results into the register file's single write port and
// tracks loads that have issued but not yet been written back.
//   clk, rst            : clock, synchronous active-high reset
//   alu_valid/rd/wd     : ALU result, never stalled
//   ld_issue/ld_issue_rd: load issued; marks its destination pending
//   ld (slave modport)  : load data handshake, buffered in a small FIFO
//   chk_rs1/rs2/rd      : decode operands checked against pending loads
//   stall               : combinational hazard against a pending load
//   WE/wR/wD            : registered register-file write port
// Priority: ALU, then FIFO head, then bypass of a handshake into an empty FIFO.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int LDQ_DEPTH = 4,
    parameter int PTR_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_wd,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    regfile_wb_arbiter_if.slave   ld,
    input  logic [REG_ADDR_W-1:0] chk_rs1,
    input  logic [REG_ADDR_W-1:0] chk_rs2,
    input  logic [REG_ADDR_W-1:0] chk_rd,
    output logic                  stall,
    output logic                  WE,
    output logic [REG_ADDR_W-1:0] wR,
    output logic [XLEN-1:0]       wD
);

    localparam int NREGS = 1 << REG_ADDR_W;

    wb_src_e          sel;
    wb_req_t          sel_req;
    wb_req_t          ld_req;
    wb_req_t          fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_push;
    logic             fifo_pop;
    logic             ld_hs;
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pend_set;
    logic [NREGS-1:0] pend_clr;

    // ready is forced low during reset so nothing is accepted into a FIFO
    // that is being cleared on the same edge.
    assign ld.ld_ready = !rst && !fifo_full;
    assign ld_hs       = ld.ld_valid && ld.ld_ready;
    assign ld_req      = '{rd: ld.ld_rd, wd: ld.ld_wd};

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel     = SRC_NONE;
        sel_req = '0;
        if (alu_valid) begin
            sel     = SRC_ALU;
            sel_req = '{rd: alu_rd, wd: alu_wd};
        end else if (!fifo_empty) begin
            sel     = SRC_FIFO;
            sel_req = fifo_head;
        end else if (ld_hs) begin
            sel     = SRC_BYP;
            sel_req = ld_req;
        end
    end

    // A head entry is consumed whenever it is selected, including rd==0.
    assign fifo_pop  = (sel == SRC_FIFO);
    assign fifo_push = ld_hs && (sel != SRC_BYP);

    wb_ldq_fifo #(
        .DEPTH (LDQ_DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (REG_ADDR_W + XLEN)
    ) u_ldq (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (ld_req),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Writes to x0 are consumed but never reach the register file; wR/wD keep
    // their last real write.
    always_ff @(posedge clk) begin
        if (rst) begin
            WE <= 1'b0;
            wR <= '0;
            wD <= '0;
        end else begin
            WE <= 1'b0;
            if (sel != SRC_NONE && sel_req.rd != '0) begin
                WE <= 1'b1;
                wR <= sel_req.rd;
                wD <= sel_req.wd;
            end
        end
    end

    // The clear lands on the same edge the write is registered, so decode
    // sees the hazard drop as soon as WE/wR show the write.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (ld_issue) pend_set[ld_issue_rd] = 1'b1;
        if (sel == SRC_FIFO || sel == SRC_BYP) pend_clr[sel_req.rd] = 1'b1;
    end

    // Set is applied after clear so a same-cycle re-issue keeps the bit;
    // bit 0 is masked because x0 never carries a hazard.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= ((pending & ~pend_clr) | pend_set) & ~NREGS'(1);
    end

    assign stall = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd];

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        fifo_count <= (PTR_W+1)'(LDQ_DEPTH));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed, table-driven bench for regfile_wb_arbiter. Each table row is the
// input set for one clock cycle and the outputs expected just after that edge.
// Multi-cycle corners (FIFO fill under ALU pressure, reset mid-operation) are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_wd;
    logic                  ld_issue;
    logic [REG_ADDR_W-1:0] ld_issue_rd;
    logic [REG_ADDR_W-1:0] chk_rs1;
    logic [REG_ADDR_W-1:0] chk_rs2;
    logic [REG_ADDR_W-1:0] chk_rd;
    logic                  stall;
    logic                  WE;
    logic [REG_ADDR_W-1:0] wR;
    logic [XLEN-1:0]       wD;

    regfile_wb_arbiter_if ld_if ();

    regfile_wb_arbiter #(.LDQ_DEPTH(4), .PTR_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_wd      (alu_wd),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld          (ld_if),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .chk_rd      (chk_rd),
        .stall       (stall),
        .WE          (WE),
        .wR          (wR),
        .wD          (wD)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] awd;
        logic        iss;
        logic [4:0]  isrd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] lwd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        e_we;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic r, input logic av, input logic [4:0] ard, input logic [31:0] awd,
        input logic iss, input logic [4:0] isrd,
        input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic ewe, input logic [4:0] ewr, input logic [31:0] ewd,
        input logic erdy, input logic est);
        vec_t v;
        v.rst = r;  v.av = av;  v.ard = ard;  v.awd = awd;
        v.iss = iss; v.isrd = isrd;
        v.lv = lv;  v.lrd = lrd;  v.lwd = lwd;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.e_we = ewe; v.e_wr = ewr; v.e_wd = ewd; v.e_rdy = erdy; v.e_stall = est;
        return v;
    endfunction

    task automatic idle();
        rst = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
        ld_issue = 1'b0; ld_issue_rd = '0;
        ld_if.ld_valid = 1'b0; ld_if.ld_rd = '0; ld_if.ld_wd = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic hs;

        idle();
        rst = 1'b1;

        //            rst av ard    awd         iss isrd lv lrd   lwd          rs1 rs2 rd   WE wR  wD           rdy st
        vecs.push_back(mk(1, 1, 5'd3, 32'hAAAA_AAAA, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 0));
        vecs.push_back(mk(1, 1, 5'd3, 32'hAAAA_AAAA, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd31, 5'd17, 5'd1, 0, 5'd0, 32'h0, 1, 0));
        // ALU path, then ALU to x0
        vecs.push_back(mk(0, 1, 5'd5, 32'h1234_5678, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1, 5'd5, 32'h1234_5678, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd5, 32'h1234_5678, 1, 0));
        vecs.push_back(mk(0, 1, 5'd0, 32'hFFFF_0000, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd5, 32'h1234_5678, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd5, 32'h1234_5678, 1, 0));
        // load bypass and scoreboard on rs1
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd7, 0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd0, 0, 5'd5, 32'h1234_5678, 1, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd0, 0, 5'd5, 32'h1234_5678, 1, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd0, 0, 5'd5, 32'h1234_5678, 1, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd0, 5'd0, 1, 5'd7, 32'hDEAD_BEEF, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd0, 0, 5'd7, 32'hDEAD_BEEF, 1, 0));
        // ALU beats a load: load buffered, drains next cycle; hazard on chk_rd
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd20, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd20, 0, 5'd7, 32'hDEAD_BEEF, 1, 1));
        vecs.push_back(mk(0, 1, 5'd2, 32'h22, 0, 5'd0, 1, 5'd20, 32'h5, 5'd0, 5'd0, 5'd20, 1, 5'd2, 32'h22, 1, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd20, 1, 5'd20, 32'h5, 1, 0));
        // set/clear collision on rd 9: set wins
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd9, 0, 5'd0, 32'h0, 5'd0, 5'd9, 5'd0, 0, 5'd20, 32'h5, 1, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd9, 1, 5'd9, 32'h99, 5'd0, 5'd9, 5'd0, 1, 5'd9, 32'h99, 1, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd9, 5'd0, 0, 5'd9, 32'h99, 1, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd9, 32'h9A, 5'd0, 5'd9, 5'd0, 1, 5'd9, 32'h9A, 1, 0));
        // load to x0 bypassed and dropped
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd0, 32'h77, 5'd0, 5'd0, 5'd0, 0, 5'd9, 32'h9A, 1, 0));
        // x0 load buffered behind ALU: its head is popped and dropped, rd 11 follows
        vecs.push_back(mk(0, 1, 5'd3, 32'h33, 0, 5'd0, 1, 5'd0, 32'h44, 5'd0, 5'd0, 5'd0, 1, 5'd3, 32'h33, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd11, 32'h55, 5'd0, 5'd0, 5'd0, 0, 5'd3, 32'h33, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1, 5'd11, 32'h55, 1, 0));
        // issue to x0 never marks pending
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd11, 32'h55, 1, 0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_wd = vecs[i].awd;
            ld_issue = vecs[i].iss; ld_issue_rd = vecs[i].isrd;
            ld_if.ld_valid = vecs[i].lv; ld_if.ld_rd = vecs[i].lrd; ld_if.ld_wd = vecs[i].lwd;
            chk_rs1 = vecs[i].rs1; chk_rs2 = vecs[i].rs2; chk_rd = vecs[i].rd;
            step();
            check($sformatf("v%0d WE", i), 32'(WE), 32'(vecs[i].e_we));
            check($sformatf("v%0d wR", i), 32'(wR), 32'(vecs[i].e_wr));
            check($sformatf("v%0d wD", i), wD, vecs[i].e_wd);
            check($sformatf("v%0d ld_ready", i), 32'(ld_if.ld_ready), 32'(vecs[i].e_rdy));
            check($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
        end

        // no register is pending at this point
        idle();
        for (int r = 0; r < 32; r++) begin
            chk_rs1 = 5'(r); chk_rs2 = 5'(r); chk_rd = 5'(r);
            #1;
            check($sformatf("clean stall r%0d", r), 32'(stall), 32'd0);
        end

        // FIFO fill under continuous ALU traffic, then in-order drain
        idle();
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'h100 + 32'(c);
            ld_if.ld_valid = (acc < 5);
            ld_if.ld_rd = 5'(10 + acc);
            ld_if.ld_wd = 32'h1000 + 32'(acc);
            #1;
            hs = ld_if.ld_valid && ld_if.ld_ready;
            step();
            if (hs) acc++;
            check($sformatf("fill c%0d WE", c), 32'(WE), 32'd1);
            check($sformatf("fill c%0d wR", c), 32'(wR), 32'd1);
            check($sformatf("fill c%0d wD", c), wD, 32'h100 + 32'(c));
            check($sformatf("fill c%0d ld_ready", c), 32'(ld_if.ld_ready), (c < 3) ? 32'd1 : 32'd0);
        end
        check("fill accepted", 32'(acc), 32'd4);
        alu_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ld_if.ld_valid = (acc < 5);
            ld_if.ld_rd = 5'(10 + acc);
            ld_if.ld_wd = 32'h1000 + 32'(acc);
            #1;
            hs = ld_if.ld_valid && ld_if.ld_ready;
            step();
            if (hs) acc++;
            check($sformatf("drain k%0d WE", k), 32'(WE), 32'd1);
            check($sformatf("drain k%0d wR", k), 32'(wR), 32'(10 + k));
            check($sformatf("drain k%0d wD", k), wD, 32'h1000 + 32'(k));
        end
        check("drain accepted", 32'(acc), 32'd5);
        idle();
        step();
        check("drain done WE", 32'(WE), 32'd0);

        // reset mid-operation: three buffered loads and pending bits discarded
        for (int j = 0; j < 3; j++) begin
            alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'h200 + 32'(j);
            ld_issue = 1'b1; ld_issue_rd = 5'(4 + j);
            ld_if.ld_valid = 1'b1; ld_if.ld_rd = 5'(4 + j); ld_if.ld_wd = 32'h400 + 32'(j);
            chk_rs1 = 5'd4;
            step();
        end
        check("pre-reset stall", 32'(stall), 32'd1);
        idle();
        rst = 1'b1;
        chk_rs1 = 5'd4;
        step();
        check("rst WE", 32'(WE), 32'd0);
        check("rst ld_ready", 32'(ld_if.ld_ready), 32'd0);
        check("rst wR", 32'(wR), 32'd0);
        rst = 1'b0;
        chk_rs1 = 5'd4; chk_rs2 = 5'd5; chk_rd = 5'd6;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("post-rst k%0d WE", k), 32'(WE), 32'd0);
            check($sformatf("post-rst k%0d ld_ready", k), 32'(ld_if.ld_ready), 32'd1);
            check($sformatf("post-rst k%0d stall", k), 32'(stall), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
